// File: rtl/srjf_task_feeder.sv
// srjf_task_feeder: preloaded task table feeding the SRJF scheduler.
// Issues each entry at its arrival time and mirrors the scheduler's slots
// from task_out so it never issues into a full scheduler.
module srjf_task_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned SLOTS   = 5,
  parameter int unsigned ID_W    = 16,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned ARR_W   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load_en,
  input  logic [ARR_W+BURST_W+ID_W-1:0]  i_load_data,
  output logic                           o_load_err,
  input  logic                           i_go,
  input  logic                           i_clr,
  output logic                           o_st,
  output logic                           o_inputtask,
  output logic [BURST_W+ID_W-1:0]        o_task_in,
  input  logic [ID_W-1:0]                i_task_out,
  input  logic                           i_sched_empty,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [3:0]                     o_issued_cnt,
  output logic [7:0]                     o_stall_cnt
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned SLOT_W = $clog2(SLOTS + 1);
  localparam int unsigned SI_W   = $clog2(SLOTS);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StDrain, StDone} state_e;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt, r_rptr;
  logic [ARR_W-1:0]     r_timer;
  logic                 r_load_err, r_st, r_inputtask, r_busy, r_done;
  logic [BURST_W+ID_W-1:0] r_task_in;
  logic [3:0]           r_issued;
  logic [7:0]           r_stall;

  logic [ARR_W-1:0]     r_tab_arr   [DEPTH];
  logic [BURST_W-1:0]   r_tab_burst [DEPTH];
  logic [ID_W-1:0]      r_tab_id    [DEPTH];

  logic [SLOTS-1:0]     r_mv;
  logic [ID_W-1:0]      r_mid  [SLOTS];
  logic [BURST_W-1:0]   r_mrem [SLOTS];

  logic                 w_load_req, w_load_ok, w_load_rej;
  logic [IDX_W-1:0]     w_ridx;
  logic [ARR_W-1:0]     w_head_arr, w_tnext;
  logic [BURST_W-1:0]   w_head_burst;
  logic [ID_W-1:0]      w_head_id;
  logic                 w_active, w_elig, w_room, w_issue, w_skip, w_stall, w_track;
  logic [SLOT_W-1:0]    w_mcnt;
  logic                 w_hit, w_free_found;
  logic [SI_W-1:0]      w_hit_idx, w_free_idx;

  // Load acceptance; clr takes priority over a same-cycle load
  assign w_load_req = (r_state == StIdle) && i_load_en && !i_clr;
  assign w_load_rej = w_load_req && ((r_cnt == CNT_W'(DEPTH)) || (i_load_data[ID_W-1:0] == '1));
  assign w_load_ok  = w_load_req && !w_load_rej;

  // Head-of-table issue decision; timer compare uses the value visible with the issue
  assign w_ridx       = r_rptr[IDX_W-1:0];
  assign w_head_arr   = r_tab_arr[w_ridx];
  assign w_head_burst = r_tab_burst[w_ridx];
  assign w_head_id    = r_tab_id[w_ridx];
  assign w_tnext      = (r_state == StStart) ? '0 :
                        (r_timer == '1)      ? r_timer : r_timer + ARR_W'(1);
  assign w_active     = (r_state == StStart) || (r_state == StRun);
  assign w_elig       = w_active && (r_rptr < r_cnt) && (w_tnext >= w_head_arr);
  assign w_room       = w_mcnt < SLOT_W'(SLOTS);
  assign w_skip       = w_elig && (w_head_burst == '0);
  assign w_issue      = w_elig && (w_head_burst != '0) && w_room;
  assign w_stall      = w_elig && (w_head_burst != '0) && !w_room;
  assign w_track      = (w_active || (r_state == StDrain)) && (i_task_out != '1);

  // Mirror occupancy, lowest matching entry and lowest free entry
  always_comb begin
    w_mcnt       = '0;
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_mv[i]) w_mcnt = w_mcnt + SLOT_W'(1);
      if (r_mv[i] && (r_mid[i] == i_task_out) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_idx = SI_W'(i);
      end
      if (!r_mv[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = SI_W'(i);
      end
    end
  end

  // Task table storage; validity is tracked by r_cnt
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_tab_arr[r_cnt[IDX_W-1:0]]   <= i_load_data[ARR_W+BURST_W+ID_W-1 -: ARR_W];
      r_tab_burst[r_cnt[IDX_W-1:0]] <= i_load_data[BURST_W+ID_W-1 -: BURST_W];
      r_tab_id[r_cnt[IDX_W-1:0]]    <= i_load_data[ID_W-1:0];
    end
  end

  // Slot mirror: decrement on task_out, free at zero, allocate on issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mv <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_mid[i]  <= '0;
        r_mrem[i] <= '0;
      end
    end else begin
      if (w_track && w_hit) begin
        if (r_mrem[w_hit_idx] == BURST_W'(1)) r_mv[w_hit_idx] <= 1'b0;
        else r_mrem[w_hit_idx] <= r_mrem[w_hit_idx] - BURST_W'(1);
      end
      // Allocation only happens with a slot already free, never the one being released
      if (w_issue) begin
        r_mv[w_free_idx]   <= 1'b1;
        r_mid[w_free_idx]  <= w_head_id;
        r_mrem[w_free_idx] <= w_head_burst;
      end
    end
  end

  // Run control FSM with registered outputs and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rptr      <= '0;
      r_timer     <= '0;
      r_load_err  <= 1'b0;
      r_st        <= 1'b0;
      r_inputtask <= 1'b0;
      r_task_in   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_issued    <= '0;
      r_stall     <= '0;
    end else begin
      r_load_err  <= w_load_rej;
      r_st        <= 1'b0;
      r_inputtask <= w_issue;
      r_task_in   <= w_issue ? {w_head_burst, w_head_id} : '0;
      if (w_load_ok) r_cnt <= r_cnt + CNT_W'(1);
      if (w_issue || w_skip) r_rptr <= r_rptr + CNT_W'(1);
      if (w_issue) r_issued <= r_issued + 4'd1;
      if (w_stall && (r_stall != '1)) r_stall <= r_stall + 8'd1;
      case (r_state)
        StIdle, StDone: begin
          if (i_clr) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end else if (i_go) begin
            r_state  <= StStart;
            r_st     <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_timer  <= '0;
            r_rptr   <= '0;
            r_issued <= '0;
            r_stall  <= '0;
          end
        end
        StStart: begin
          r_state <= StRun;
          r_timer <= '0;
        end
        StRun: begin
          r_timer <= w_tnext;
          if (r_rptr == r_cnt) r_state <= StDrain;
        end
        StDrain: begin
          if ((w_mcnt == '0) && i_sched_empty) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_load_err   = r_load_err;
  assign o_st         = r_st;
  assign o_inputtask  = r_inputtask;
  assign o_task_in    = r_task_in;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_issued_cnt = r_issued;
  assign o_stall_cnt  = r_stall;

endmodule

// File: tb/tb_srjf_task_feeder.sv
// Self-checking bench for srjf_task_feeder: directed scenarios plus
// randomized runs against a queue-based reference model.
module tb_srjf_task_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_load_en;
  logic [25:0] i_load_data;
  logic        o_load_err;
  logic        i_go, i_clr;
  logic        o_st, o_inputtask;
  logic [19:0] o_task_in;
  logic [15:0] i_task_out;
  logic        i_sched_empty;
  logic        o_busy, o_done;
  logic [3:0]  o_issued_cnt;
  logic [7:0]  o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  srjf_task_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .i_load_en     (i_load_en),
    .i_load_data   (i_load_data),
    .o_load_err    (o_load_err),
    .i_go          (i_go),
    .i_clr         (i_clr),
    .o_st          (o_st),
    .o_inputtask   (o_inputtask),
    .o_task_in     (o_task_in),
    .i_task_out    (i_task_out),
    .i_sched_empty (i_sched_empty),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_issued_cnt  (o_issued_cnt),
    .o_stall_cnt   (o_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_load_en = 1'b0; i_load_data = '0; i_go = 1'b0; i_clr = 1'b0;
    i_task_out = 16'hFFFF; i_sched_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_entry(input int arr, input int bur, input logic [15:0] id);
    i_load_en = 1'b1;
    i_load_data = {6'(arr), 4'(bur), id};
    tick();
    i_load_en = 1'b0;
  endtask

  task automatic pulse_go();
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] id; int rem; } ment_t;
  ment_t       mq[$];
  int          m_arr[$];
  int          m_bur[$];
  logic [15:0] m_id[$];
  int          m_phase;  // 0 idle, 1 start, 2 run, 3 drain, 4 done
  int          m_timer, m_head, m_issued, m_stall;
  bit          e_st, e_it;
  logic [19:0] e_ti;

  task automatic model_step(input bit go, input bit clr, input logic [15:0] tout, input bit semp);
    int pre_size = mq.size();
    int pre_head = m_head;
    int tn = 0;
    e_st = 0; e_it = 0; e_ti = '0;
    if (m_phase == 0 || m_phase == 4) begin
      if (clr) begin
        m_arr.delete(); m_bur.delete(); m_id.delete(); m_phase = 0;
      end else if (go) begin
        m_phase = 1; e_st = 1; m_head = 0; m_issued = 0; m_stall = 0; m_timer = 0;
      end
    end else begin
      if (tout != 16'hFFFF) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].id == tout) begin
            mq[i].rem = mq[i].rem - 1;
            if (mq[i].rem == 0) mq.delete(i);
            break;
          end
        end
      end
      if (m_phase != 3) begin
        tn = (m_phase == 1) ? 0 : ((m_timer < 63) ? m_timer + 1 : 63);
        if (m_head < m_arr.size() && tn >= m_arr[m_head]) begin
          if (m_bur[m_head] == 0) m_head++;
          else if (pre_size < 5) begin
            ment_t ne;
            e_it = 1; e_ti = {4'(m_bur[m_head]), m_id[m_head]};
            ne.id = m_id[m_head]; ne.rem = m_bur[m_head];
            mq.push_back(ne);
            m_issued++; m_head++;
          end else if (m_stall < 255) m_stall++;
        end
      end
      case (m_phase)
        1: begin m_phase = 2; m_timer = 0; end
        2: begin m_timer = tn; if (pre_head == m_arr.size()) m_phase = 3; end
        default: if (pre_size == 0 && semp) m_phase = 4;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_load_err, o_st, o_inputtask, o_task_in, o_busy, o_done, o_issued_cnt, o_stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%0b it=%0b ti=%0h busy=%0b done=%0b iss=%0d stall=%0d required all 0",
               o_st, o_inputtask, o_task_in, o_busy, o_done, o_issued_cnt, o_stall_cnt);
    end
  endtask

  task automatic test_basic();
    logic [19:0] exp_ti [3];
    logic [15:0] touts [6];
    exp_ti = '{20'h30001, 20'h10002, 20'h20003};
    touts  = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h3, 16'h3};
    do_reset();
    load_entry(0, 3, 16'h0001);
    load_entry(1, 1, 16'h0002);
    load_entry(2, 2, 16'h0003);
    pulse_go();
    n_checks++;
    if (o_st !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: got st=%0b busy=%0b required 1 1", o_st, o_busy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (o_st !== 1'b0 || o_inputtask !== 1'b1 || o_task_in !== exp_ti[c]) begin
        n_fail++;
        $display("FAIL basic_issue%0d: got st=%0b it=%0b ti=%0h required 0 1 %0h",
                 c, o_st, o_inputtask, o_task_in, exp_ti[c]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      i_task_out = touts[k];
      tick();
    end
    i_task_out = 16'hFFFF; i_sched_empty = 1'b1;
    for (int k = 0; k < 20 && !o_done; k++) tick();
    n_checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_issued_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_done: got done=%0b busy=%0b iss=%0d required 1 0 3", o_done, o_busy, o_issued_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 7; i++) load_entry(0, 15, 16'(i));
    pulse_go();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (o_inputtask !== 1'b1 || o_task_in !== {4'hF, 16'(c + 1)}) begin
        n_fail++; $display("FAIL stall_fill%0d: got it=%0b ti=%0h required 1 %0h",
                           c, o_inputtask, o_task_in, {4'hF, 16'(c + 1)});
      end
    end
    tick();
    n_checks++;
    if (o_inputtask !== 1'b0 || o_stall_cnt !== 8'd1) begin
      n_fail++; $display("FAIL stall_first: got it=%0b stall=%0d required 0 1", o_inputtask, o_stall_cnt);
    end
    tick();
    n_checks++;
    if (o_stall_cnt !== 8'd2) begin
      n_fail++; $display("FAIL stall_count: got %0d required 2", o_stall_cnt);
    end
    i_task_out = 16'h0001;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_checks++;
      if (o_inputtask !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got it=%0b required 0", k, o_inputtask);
      end
    end
    i_task_out = 16'hFFFF;
    tick();
    n_checks++;
    if (o_inputtask !== 1'b1 || o_task_in !== 20'hF0006 || o_stall_cnt !== 8'd17) begin
      n_fail++; $display("FAIL stall_release: got it=%0b ti=%0h stall=%0d required 1 f0006 17",
                         o_inputtask, o_task_in, o_stall_cnt);
    end
  endtask

  task automatic test_arrival();
    do_reset();
    load_entry(5, 2, 16'h00AA);
    pulse_go();
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if (o_inputtask !== 1'b0) begin
        n_fail++; $display("FAIL arrival_early%0d: got it=%0b required 0", t, o_inputtask);
      end
    end
    tick();
    n_checks++;
    if (o_inputtask !== 1'b1 || o_task_in !== 20'h200AA) begin
      n_fail++; $display("FAIL arrival_issue: got it=%0b ti=%0h required 1 200aa", o_inputtask, o_task_in);
    end
  endtask

  task automatic test_burst0();
    do_reset();
    load_entry(0, 0, 16'h0010);
    load_entry(0, 1, 16'h0011);
    pulse_go();
    tick();
    n_checks++;
    if (o_inputtask !== 1'b0) begin
      n_fail++; $display("FAIL burst0_skip: got it=%0b ti=%0h required 0", o_inputtask, o_task_in);
    end
    tick();
    n_checks++;
    if (o_inputtask !== 1'b1 || o_task_in !== 20'h10011) begin
      n_fail++; $display("FAIL burst0_next: got it=%0b ti=%0h required 1 10011", o_inputtask, o_task_in);
    end
    i_task_out = 16'h0011;
    tick();
    i_task_out = 16'hFFFF; i_sched_empty = 1'b1;
    for (int k = 0; k < 20 && !o_done; k++) tick();
    n_checks++;
    if (o_done !== 1'b1 || o_issued_cnt !== 4'd1) begin
      n_fail++; $display("FAIL burst0_done: got done=%0b iss=%0d required 1 1", o_done, o_issued_cnt);
    end
  endtask

  task automatic test_load_err();
    do_reset();
    load_entry(0, 1, 16'hFFFF);
    n_checks++;
    if (o_load_err !== 1'b1) begin
      n_fail++; $display("FAIL load_err_id: got %0b required 1", o_load_err);
    end
    for (int i = 0; i < 8; i++) begin
      load_entry(i, 0, 16'(i + 32));
      n_checks++;
      if (o_load_err !== 1'b0) begin
        n_fail++; $display("FAIL load_ok%0d: got err=%0b required 0", i, o_load_err);
      end
    end
    load_entry(9, 1, 16'h0040);
    n_checks++;
    if (o_load_err !== 1'b1) begin
      n_fail++; $display("FAIL load_err_full: got %0b required 1", o_load_err);
    end
    tick();
    n_checks++;
    if (o_load_err !== 1'b0) begin
      n_fail++; $display("FAIL load_err_pulse: got %0b required 0", o_load_err);
    end
    i_sched_empty = 1'b1;
    pulse_go();
    for (int k = 0; k < 30 && !o_done; k++) tick();
    n_checks++;
    if (o_done !== 1'b1 || o_issued_cnt !== 4'd0) begin
      n_fail++; $display("FAIL load_run_done: got done=%0b iss=%0d required 1 0", o_done, o_issued_cnt);
    end
    i_go = 1'b1; i_clr = 1'b1;
    tick();
    i_go = 1'b0; i_clr = 1'b0;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_st !== 1'b0) begin
      n_fail++; $display("FAIL go_clr: got done=%0b busy=%0b st=%0b required 0 0 0", o_done, o_busy, o_st);
    end
    load_entry(0, 1, 16'h0050);
    n_checks++;
    if (o_load_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_empties: got err=%0b required 0", o_load_err);
    end
  endtask

  task automatic test_rst_midrun();
    do_reset();
    load_entry(0, 2, 16'h0005);
    pulse_go();
    tick();
    n_checks++;
    if (o_inputtask !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got it=%0b required 1", o_inputtask);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_inputtask !== 1'b0 || o_st !== 1'b0 || o_busy !== 1'b0 || o_task_in !== '0) begin
      n_fail++; $display("FAIL rst_async: got it=%0b st=%0b busy=%0b ti=%0h required 0 0 0 0",
                         o_inputtask, o_st, o_busy, o_task_in);
    end
    #1 rst = 1'b0;
    i_sched_empty = 1'b0;
    pulse_go();
    repeat (5) tick();
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_empty: got done=%0b busy=%0b required 0 1", o_done, o_busy);
    end
    i_sched_empty = 1'b1;
    for (int k = 0; k < 10 && !o_done; k++) tick();
    n_checks++;
    if (o_done !== 1'b1 || o_issued_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_empty_run: got done=%0b iss=%0d required 1 0", o_done, o_issued_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n = $urandom_range(8, 1);
      int arr = 0;
      logic [15:0] tout;
      bit semp;
      do_reset();
      mq.delete(); m_arr.delete(); m_bur.delete(); m_id.delete();
      m_phase = 0; m_timer = 0; m_head = 0; m_issued = 0; m_stall = 0;
      for (int i = 0; i < n; i++) begin
        arr = arr + $urandom_range(3);
        m_arr.push_back(arr);
        m_bur.push_back($urandom_range(5));
        m_id.push_back(16'(it * 16 + i + 1));
        load_entry(arr, m_bur[i], m_id[i]);
      end
      i_go = 1'b1;
      model_step(1'b1, 1'b0, 16'hFFFF, 1'b0);
      tick();
      i_go = 1'b0;
      for (int cyc = 0; cyc < 400 && m_phase != 4; cyc++) begin
        bit e_busy, e_done;
        if (cyc > 0) begin
          if (mq.size() > 0 && $urandom_range(3) != 0) tout = mq[$urandom_range(mq.size() - 1)].id;
          else if ($urandom_range(7) == 0) tout = 16'h7777;
          else tout = 16'hFFFF;
          semp = 1'($urandom_range(1));
          i_task_out = tout; i_sched_empty = semp;
          model_step(1'b0, 1'b0, tout, semp);
          tick();
        end
        e_busy = (m_phase >= 1 && m_phase <= 3);
        e_done = (m_phase == 4);
        n_checks++;
        if ({o_inputtask, o_task_in} !== {e_it, e_ti}) begin
          n_fail++; $display("FAIL rand%0d_issue c%0d: got it=%0b ti=%0h required %0b %0h",
                             it, cyc, o_inputtask, o_task_in, e_it, e_ti);
        end
        n_checks++;
        if ({o_st, o_busy, o_done} !== {e_st, e_busy, e_done}) begin
          n_fail++; $display("FAIL rand%0d_state c%0d: got st/busy/done=%0b%0b%0b required %0b%0b%0b",
                             it, cyc, o_st, o_busy, o_done, e_st, e_busy, e_done);
        end
        n_checks++;
        if (o_issued_cnt !== 4'(m_issued) || o_stall_cnt !== 8'(m_stall)) begin
          n_fail++; $display("FAIL rand%0d_stats c%0d: got iss=%0d stall=%0d required %0d %0d",
                             it, cyc, o_issued_cnt, o_stall_cnt, m_issued, m_stall);
        end
      end
      n_checks++;
      if (m_phase != 4 || o_done !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_timeout: got done=%0b required 1", it, o_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_arrival();
    test_burst0();
    test_load_err();
    test_rst_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srjf_task_feeder.md
Name: srjf_task_feeder

Overview:
Task source for the SRJF scheduler. It drives the scheduler's st, inputtask and task_in ports from a preloaded task table. It issues each task at its programmed arrival cycle and mirrors the scheduler's 5 slots by watching task_out, so it never issues into a full scheduler. It reports run completion and stall statistics to the bench or top level.

Parameters:
DEPTH, 8, number of task-table entries
SLOTS, 5, scheduler slot count mirrored by the feeder
ID_W, 16, task id width; must match scheduler task_out width
BURST_W, 4, burst (remaining-time) width; must match scheduler task_in[19:16]
ARR_W, 6, arrival-time width; also the RUN timer width

Ports:
clk  in  1  clock
rst  in  1  reset
load_en  in  1  write load_data into the next table entry; accepted in IDLE only
load_data  in  ARR_W+BURST_W+ID_W  {arrival, burst, id}
load_err  out  1  one-cycle pulse when a load is rejected
go  in  1  start a run; accepted in IDLE and DONE
clr  in  1  empty the table and return to IDLE; accepted in IDLE and DONE
st  out  1  scheduler start pulse
inputtask  out  1  scheduler task-valid
task_in  out  BURST_W+ID_W  {burst, id} to scheduler; 0 when inputtask=0
task_out  in  ID_W  scheduler's executing id; all-ones means idle
sched_empty  in  1  scheduler empty flag
busy  out  1  high in START, RUN and DRAIN
done  out  1  high in DONE
issued_cnt  out  4  tasks issued this run
stall_cnt  out  8  saturating count of stall cycles (head eligible, no free slot)

Behaviour:
- One clock, clk; reset is rst, asynchronous, active-high.
- Reset values: all outputs 0, table empty, state IDLE, timer 0, mirror empty.
- All outputs are registered.
- Loading:
  - A load is rejected with a load_err pulse when the table is full or when id is all-ones. A rejected load writes nothing.
  - Tasks must be loaded in non-decreasing arrival order. Issue is strictly in table order.
- States:
  - IDLE: go -> START.
  - START: st=1 for exactly one cycle -> RUN. The timer, read pointer, issued_cnt and stall_cnt clear on entry.
  - RUN: the first RUN cycle is timer 0 and coincides with the scheduler's first exec cycle. The timer increments each cycle and saturates at 2^ARR_W-1. When every table entry has been consumed -> DRAIN.
  - DRAIN: -> DONE when mirror occupancy is 0 and sched_empty=1 in the same cycle.
  - DONE: go -> START (re-run the same table); clr -> IDLE.
- Issue rule (RUN): at most one task per cycle. The head entry issues when timer >= arrival, burst != 0, and the registered mirror count is < SLOTS.
  - On issue: inputtask=1 and task_in={burst,id} in the next cycle; a mirror entry {id, burst} is allocated at the same edge; issued_cnt increments.
- Burst 0: the head entry is consumed without issuing, one entry per cycle, and is not counted in issued_cnt.
- Stall: head eligible by time but mirror count = SLOTS -> stall_cnt +1 (saturating).
- Mirror tracking, every cycle outside IDLE/DONE:
  - If task_out != all-ones, decrement the lowest-index valid mirror entry whose id matches. Reaching 0 frees the entry at the same edge.
  - task_out matching no entry is ignored.
- Free-slot decisions use the occupancy before the current edge. A slot freed at edge t is usable for an issue decided in cycle t+1, which matches the scheduler's registered store.
- Simultaneous go and clr: clr wins.
- rst mid-run: immediate return to the reset state; the table is lost and st/inputtask drop asynchronously. The scheduler must be reset separately.

Test Plan:
- Load {0,3,0x0001},{1,1,0x0002},{2,2,0x0003}, pulse go -> st=1 for 1 cycle; then task_in=0x30001, 0x10002, 0x20003 on RUN cycles 0, 1, 2; with scheduler attached, DONE after all 6 burst units and issued_cnt=3.
- Load 7 tasks, arrival 0, burst 15, ids 1..7; hold task_out=0xFFFF -> issues on RUN cycles 0-4, stall_cnt counts up from cycle 5. Then drive task_out=0x0001 for 15 cycles -> id 6 issues exactly one cycle after the 15th.
- Load {5,2,0x00AA} -> inputtask stays 0 for RUN cycles 0-4 and is 1 exactly at timer 5.
- Load burst 0 entry {0,0,0x0010}, then {0,1,0x0011} -> 0x0010 is never issued; 0x0011 issues; issued_cnt=1.
- Load with id 0xFFFF, and a 9th load -> load_err pulses each time and the table count is unchanged; go+clr together in DONE -> IDLE.
- Assert rst during RUN with inputtask=1 -> inputtask, st and busy are 0 before the next clk edge; the next go with an empty table -> DONE once sched_empty=1.
